// File: rtl/sdram_arb_pkg.sv
// Shared types and default widths for the SDRAM access arbiter.
package sdram_arb_pkg;

   localparam int ADDR_W = 26;
   localparam int DATA_W = 32;

   typedef enum logic [1:0] {IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE} arb_state_t;
   typedef enum logic {GRANT_RD, GRANT_WR} grant_t;

endpackage

// File: rtl/sdram_access_arbiter.sv
// Shares the single SDRAM port between the pixel-fetch reader and the write-back writer,
// with round-robin arbitration, base-address offsetting and a read timeout.
module sdram_access_arbiter #(
   parameter int ADDR_W     = sdram_arb_pkg::ADDR_W,
   parameter int DATA_W     = sdram_arb_pkg::DATA_W,
   parameter int RD_TIMEOUT = 255,
   parameter int TO_W       = 8
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic [ADDR_W-1:0] start_addr_sdram,
   input  logic [ADDR_W-1:0] finish_addr_sdram,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_offset,
   output logic              rd_done,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_err,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] wr_offset,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ack,
   output logic              sdram_read_en,
   output logic              sdram_write_en,
   output logic [ADDR_W-1:0] address_sdram,
   output logic [DATA_W-1:0] writeData_sdram,
   input  logic [DATA_W-1:0] data_sdram,
   input  logic              sdram_datareadvalid,
   output logic              busy,
   output logic              timeout_seen
);

   import sdram_arb_pkg::*;

   localparam logic [TO_W-1:0] TO_LAST = TO_W'(RD_TIMEOUT - 1);

   arb_state_t        state_q, state_d;
   grant_t            last_grant_q, last_grant_d;
   logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
   logic              read_en_q, read_en_d;
   logic              write_en_q, write_en_d;
   logic              wr_ack_q, wr_ack_d;
   logic              rd_done_q, rd_done_d;
   logic              rd_err_q, rd_err_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              timeout_seen_q, timeout_seen_d;
   logic              busy_q, busy_d;
   logic [ADDR_W-1:0] rd_addr, wr_addr;
   logic              can_grant;

   assign rd_addr = start_addr_sdram + rd_offset;
   assign wr_addr = finish_addr_sdram + wr_offset;

   // The IDLE cycle carrying rd_done is not a grant slot: the reader still holds rd_req there.
   assign can_grant = !rd_done_q;

   always_comb begin
      state_d        = state_q;
      last_grant_d   = last_grant_q;
      to_cnt_d       = to_cnt_q;
      read_en_d      = 1'b0;
      write_en_d     = 1'b0;
      wr_ack_d       = 1'b0;
      rd_done_d      = 1'b0;
      rd_err_d       = 1'b0;
      rd_data_d      = rd_data_q;
      addr_d         = addr_q;
      wdata_d        = wdata_q;
      timeout_seen_d = timeout_seen_q;
      case (state_q)
         IDLE: begin
            if (can_grant && rd_req && (!wr_req || last_grant_q == GRANT_WR)) begin
               state_d      = RD_ISSUE;
               last_grant_d = GRANT_RD;
               read_en_d    = 1'b1;
               addr_d       = rd_addr;
            end else if (can_grant && wr_req) begin
               state_d      = WR_ISSUE;
               last_grant_d = GRANT_WR;
               write_en_d   = 1'b1;
               wr_ack_d     = 1'b1;
               addr_d       = wr_addr;
               wdata_d      = wr_data;
            end
         end
         RD_ISSUE: begin
            state_d  = RD_WAIT;
            to_cnt_d = '0;
         end
         RD_WAIT: begin
            if (sdram_datareadvalid) begin
               state_d   = IDLE;
               rd_done_d = 1'b1;
               rd_data_d = data_sdram;
            end else if (to_cnt_q == TO_LAST) begin
               state_d        = IDLE;
               rd_done_d      = 1'b1;
               rd_err_d       = 1'b1;
               rd_data_d      = '0;
               timeout_seen_d = 1'b1;
            end else begin
               to_cnt_d = to_cnt_q + TO_W'(1);
            end
         end
         WR_ISSUE: state_d = IDLE;
         default:  state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q        <= IDLE;
         last_grant_q   <= GRANT_WR;
         to_cnt_q       <= '0;
         read_en_q      <= 1'b0;
         write_en_q     <= 1'b0;
         wr_ack_q       <= 1'b0;
         rd_done_q      <= 1'b0;
         rd_err_q       <= 1'b0;
         rd_data_q      <= '0;
         addr_q         <= '0;
         wdata_q        <= '0;
         timeout_seen_q <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         last_grant_q   <= last_grant_d;
         to_cnt_q       <= to_cnt_d;
         read_en_q      <= read_en_d;
         write_en_q     <= write_en_d;
         wr_ack_q       <= wr_ack_d;
         rd_done_q      <= rd_done_d;
         rd_err_q       <= rd_err_d;
         rd_data_q      <= rd_data_d;
         addr_q         <= addr_d;
         wdata_q        <= wdata_d;
         timeout_seen_q <= timeout_seen_d;
         busy_q         <= busy_d;
      end
   end

   assign rd_done         = rd_done_q;
   assign rd_err          = rd_err_q;
   assign rd_data         = rd_data_q;
   assign wr_ack          = wr_ack_q;
   assign sdram_read_en   = read_en_q;
   assign sdram_write_en  = write_en_q;
   assign address_sdram   = addr_q;
   assign writeData_sdram = wdata_q;
   assign busy            = busy_q;
   assign timeout_seen    = timeout_seen_q;

endmodule

// File: tb/tb_sdram_access_arbiter.sv
// Self-checking bench for sdram_access_arbiter: vector table, hand-written corner sequences
// and randomized single-side accesses checked against a transaction-level model.
module tb_sdram_access_arbiter;

   localparam int AW    = 26;
   localparam int DW    = 32;
   localparam int RD_TO = 4;

   logic          clk = 1'b0;
   logic          n_rst = 1'b0;
   logic [AW-1:0] start_addr_sdram = '0;
   logic [AW-1:0] finish_addr_sdram = '0;
   logic          rd_req = 1'b0;
   logic [AW-1:0] rd_offset = '0;
   logic          rd_done;
   logic [DW-1:0] rd_data;
   logic          rd_err;
   logic          wr_req = 1'b0;
   logic [AW-1:0] wr_offset = '0;
   logic [DW-1:0] wr_data = '0;
   logic          wr_ack;
   logic          sdram_read_en;
   logic          sdram_write_en;
   logic [AW-1:0] address_sdram;
   logic [DW-1:0] writeData_sdram;
   logic [DW-1:0] data_sdram = '0;
   logic          sdram_datareadvalid = 1'b0;
   logic          busy;
   logic          timeout_seen;

   int  testCount = 0;
   int  failCount = 0;
   bit  expTimeoutSeen = 1'b0;

   typedef struct {
      bit            isWrite;
      logic [AW-1:0] base;
      logic [AW-1:0] offset;
      logic [DW-1:0] data;
      int            lat;
      logic [AW-1:0] expAddr;
      logic [DW-1:0] expData;
      bit            expErr;
   } vec_t;

   vec_t vecs[7];

   sdram_access_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .RD_TIMEOUT(RD_TO), .TO_W(8)
   ) dut (
      .clk(clk), .n_rst(n_rst),
      .start_addr_sdram(start_addr_sdram), .finish_addr_sdram(finish_addr_sdram),
      .rd_req(rd_req), .rd_offset(rd_offset), .rd_done(rd_done), .rd_data(rd_data), .rd_err(rd_err),
      .wr_req(wr_req), .wr_offset(wr_offset), .wr_data(wr_data), .wr_ack(wr_ack),
      .sdram_read_en(sdram_read_en), .sdram_write_en(sdram_write_en),
      .address_sdram(address_sdram), .writeData_sdram(writeData_sdram),
      .data_sdram(data_sdram), .sdram_datareadvalid(sdram_datareadvalid),
      .busy(busy), .timeout_seen(timeout_seen)
   );

   always #5 clk = ~clk;

   // One comparison: counts it, and reports a FAIL line on mismatch.
   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      testCount++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Model: address wraps modulo 2^AW.
   function automatic logic [AW-1:0] modelAddr(input logic [AW-1:0] base, input logic [AW-1:0] off);
      longint sum;
      sum = (longint'(base) + longint'(off)) % (longint'(1) << AW);
      return AW'(sum);
   endfunction

   // Read transaction: lat = RD_WAIT cycle index at which valid is driven (>= 20 means never).
   task automatic doRead(input logic [AW-1:0] base, input logic [AW-1:0] off, input logic [DW-1:0] data,
                         input int lat, input logic [AW-1:0] expAddr, input logic [DW-1:0] expData,
                         input bit expErr, input string tag);
      int  n;
      bit  got;
      int  expK;
      @(posedge clk); #1;
      start_addr_sdram = base; rd_offset = off; rd_req = 1'b1;
      got = 1'b0; n = 0;
      while (!got && n < 10) begin
         @(negedge clk);
         if (sdram_read_en) got = 1'b1;
         else begin n++; @(posedge clk); #1; end
      end
      checkOutput({tag, ".issue"}, 64'(got), 64'd1);
      if (!got) begin
         @(posedge clk); #1; rd_req = 1'b0;
         return;
      end
      checkOutput({tag, ".issue_lat"}, 64'(n), 64'd1);
      checkOutput({tag, ".addr"}, 64'(address_sdram), 64'(expAddr));
      checkOutput({tag, ".no_wr"}, 64'(sdram_write_en), 64'd0);
      got = 1'b0; n = -1;
      for (int k = 0; k < 20 && !got; k++) begin
         @(posedge clk); #1;
         if (k == 0) start_addr_sdram = ~base;
         sdram_datareadvalid = (k == lat);
         data_sdram = (k == lat) ? data : DW'($urandom);
         @(negedge clk);
         if (rd_done) begin
            got = 1'b1; n = k;
         end else if (k == 0) begin
            checkOutput({tag, ".rd_en_pulse"}, 64'(sdram_read_en), 64'd0);
            checkOutput({tag, ".addr_hold"}, 64'(address_sdram), 64'(expAddr));
         end
      end
      expK = (lat < RD_TO) ? lat + 1 : RD_TO;
      if (expErr) expTimeoutSeen = 1'b1;
      checkOutput({tag, ".done_seen"}, 64'(got), 64'd1);
      checkOutput({tag, ".done_lat"}, 64'(n), 64'(expK));
      checkOutput({tag, ".rd_data"}, 64'(rd_data), 64'(expData));
      checkOutput({tag, ".rd_err"}, 64'(rd_err), 64'(expErr));
      checkOutput({tag, ".timeout_seen"}, 64'(timeout_seen), 64'(expTimeoutSeen));
      @(posedge clk); #1;
      rd_req = 1'b0; sdram_datareadvalid = 1'b0;
      @(negedge clk);
      checkOutput({tag, ".done_pulse"}, 64'(rd_done), 64'd0);
      checkOutput({tag, ".no_dup"}, 64'({sdram_read_en, busy}), 64'd0);
   endtask

   task automatic doWrite(input logic [AW-1:0] base, input logic [AW-1:0] off, input logic [DW-1:0] data,
                          input logic [AW-1:0] expAddr, input logic [DW-1:0] expData, input string tag);
      int n;
      bit got;
      @(posedge clk); #1;
      finish_addr_sdram = base; wr_offset = off; wr_data = data; wr_req = 1'b1;
      got = 1'b0; n = 0;
      while (!got && n < 10) begin
         @(negedge clk);
         if (sdram_write_en) got = 1'b1;
         else begin n++; @(posedge clk); #1; end
      end
      checkOutput({tag, ".issue"}, 64'(got), 64'd1);
      if (got) begin
         checkOutput({tag, ".issue_lat"}, 64'(n), 64'd1);
         checkOutput({tag, ".ack"}, 64'(wr_ack), 64'd1);
         checkOutput({tag, ".addr"}, 64'(address_sdram), 64'(expAddr));
         checkOutput({tag, ".wdata"}, 64'(writeData_sdram), 64'(expData));
         checkOutput({tag, ".no_rd"}, 64'(sdram_read_en), 64'd0);
      end
      @(posedge clk); #1;
      wr_req = 1'b0; finish_addr_sdram = ~base; wr_data = ~data;
      @(negedge clk);
      checkOutput({tag, ".strobe_pulse"}, 64'({sdram_write_en, wr_ack, busy}), 64'd0);
      checkOutput({tag, ".addr_hold"}, 64'(address_sdram), 64'(expAddr));
      checkOutput({tag, ".wdata_hold"}, 64'(writeData_sdram), 64'(expData));
   endtask

   task automatic applyStimulus(input vec_t v, input string tag);
      if (v.isWrite) doWrite(v.base, v.offset, v.data, v.expAddr, v.expData, tag);
      else doRead(v.base, v.offset, v.data, v.lat, v.expAddr, v.expData, v.expErr, tag);
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, ".strobes"}, 64'({sdram_read_en, sdram_write_en, rd_done, rd_err, wr_ack}), 64'd0);
      checkOutput({tag, ".busy_to"}, 64'({busy, timeout_seen}), 64'd0);
      checkOutput({tag, ".addr"}, 64'(address_sdram), 64'd0);
      checkOutput({tag, ".wdata"}, 64'(writeData_sdram), 64'd0);
      checkOutput({tag, ".rd_data"}, 64'(rd_data), 64'd0);
   endtask

   initial begin
      vecs[0] = '{1'b0, 26'h100,     26'h5,       32'hFF204060, 1,   26'h105,     32'hFF204060, 1'b0};
      vecs[1] = '{1'b1, 26'h200,     26'h3,       32'h00A0B0C0, 0,   26'h203,     32'h00A0B0C0, 1'b0};
      vecs[2] = '{1'b0, 26'h3FFFFFE, 26'h3,       32'h12345678, 0,   26'h0000001, 32'h12345678, 1'b0};
      vecs[3] = '{1'b0, 26'h10,      26'h20,      32'hDEADBEEF, 255, 26'h30,      32'h0,        1'b1};
      vecs[4] = '{1'b0, 26'h0,       26'h3FFFFFF, 32'hCAFEF00D, 3,   26'h3FFFFFF, 32'hCAFEF00D, 1'b0};
      vecs[5] = '{1'b1, 26'h3FFFFFF, 26'h2,       32'h11223344, 0,   26'h1,       32'h11223344, 1'b0};
      vecs[6] = '{1'b0, 26'h40,      26'h0,       32'h55AA55AA, 4,   26'h40,      32'h0,        1'b1};

      #3;
      checkResetValues("reset");
      @(posedge clk); #1; n_rst = 1'b1;

      // Contention: both held, expect read, write, read, write and no overlap.
      begin
         int got, overlap;
         bit pendValid;
         bit order[4];
         got = 0; overlap = 0; pendValid = 1'b0;
         @(posedge clk); #1;
         start_addr_sdram = 26'h1000; rd_offset = 26'h1;
         finish_addr_sdram = 26'h2000; wr_offset = 26'h2; wr_data = 32'hA5A5A5A5;
         rd_req = 1'b1; wr_req = 1'b1;
         for (int c = 0; c < 80 && got < 4; c++) begin
            @(negedge clk);
            if (sdram_read_en && sdram_write_en) overlap++;
            if (sdram_read_en) begin order[got] = 1'b0; got++; end
            else if (sdram_write_en) begin order[got] = 1'b1; got++; end
            pendValid = sdram_read_en;
            @(posedge clk); #1;
            sdram_datareadvalid = pendValid;
            data_sdram = DW'($urandom);
         end
         rd_req = 1'b0; wr_req = 1'b0; sdram_datareadvalid = 1'b0;
         checkOutput("contend.count", 64'(got), 64'd4);
         for (int i = 0; i < 4; i++)
            checkOutput($sformatf("contend.order%0d", i), 64'(order[i]), 64'(i % 2));
         checkOutput("contend.overlap", 64'(overlap), 64'd0);
         repeat (8) @(posedge clk);
         #1;
      end

      for (int i = 0; i < 7; i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));

      // Stray valid pulses while idle must not produce a completion.
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         sdram_datareadvalid = 1'b1; data_sdram = DW'($urandom);
         @(negedge clk);
         checkOutput($sformatf("stray%0d", i), 64'({rd_done, busy, sdram_read_en}), 64'd0);
      end
      @(posedge clk); #1; sdram_datareadvalid = 1'b0;

      // Randomized single-side accesses against the transaction-level model.
      for (int i = 0; i < 24; i++) begin
         logic [AW-1:0] b, o;
         logic [DW-1:0] d;
         int lat;
         b = AW'($urandom);
         if ($urandom_range(1, 0) == 1) b = 26'h3FFFFF0 | AW'($urandom_range(15, 0));
         o = ($urandom_range(1, 0) == 1) ? AW'($urandom) : AW'($urandom_range(40, 0));
         d = DW'($urandom);
         lat = $urandom_range(5, 0);
         if ($urandom_range(1, 0) == 1)
            doWrite(b, o, d, modelAddr(b, o), d, $sformatf("rnd%0d", i));
         else
            doRead(b, o, d, lat, modelAddr(b, o), (lat >= RD_TO) ? '0 : d, lat >= RD_TO,
                   $sformatf("rnd%0d", i));
      end

      // Reset in the middle of RD_WAIT aborts to reset values at once.
      begin
         bit got;
         got = 1'b0;
         @(posedge clk); #1;
         start_addr_sdram = 26'h777; rd_offset = 26'h1; rd_req = 1'b1;
         for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            if (sdram_read_en) got = 1'b1;
         end
         checkOutput("rstmid.issue", 64'(got), 64'd1);
         @(posedge clk); #1;
         @(posedge clk); #1;
         n_rst = 1'b0;
         #1;
         checkResetValues("rstmid");
         rd_req = 1'b0;
         expTimeoutSeen = 1'b0;
         @(posedge clk); #1; n_rst = 1'b1;
         @(negedge clk);
         checkOutput("rstmid.no_done", 64'({rd_done, busy}), 64'd0);
      end
      doRead(26'h300, 26'h10, 32'h0BADCAFE, 2, 26'h310, 32'h0BADCAFE, 1'b0, "post_rst");

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule

// File: doc/sdram_access_arbiter.md
Name: sdram_access_arbiter

Overview:
- Shares the single external SDRAM port between two requesters.
  - Read requester: the pixel-fetch path that loads raw image words into the SRAM and window buffer.
  - Write requester: the write-back path that returns filtered pixels.
- Adds the per-direction base address, issues one-cycle read/write strobes, and waits for sdram_datareadvalid.
- Arbitrates round-robin when both sides request at once. Sits between the custom-logic sequencer and the SDRAM/Avalon-side interface.

Parameters:
- ADDR_W, 26, SDRAM word-address width
- DATA_W, 32, SDRAM data width (alpha/R/G/B bytes)
- RD_TIMEOUT, 255, max cycles in RD_WAIT before the read is aborted
- TO_W, 8, width of the timeout counter; must hold RD_TIMEOUT

Ports:
- clk  in  1  system clock, rising edge
- n_rst  in  1  asynchronous active-low reset
- start_addr_sdram  in  ADDR_W  read base address
- finish_addr_sdram  in  ADDR_W  write base address
- rd_req  in  1  read request, level, held until rd_done
- rd_offset  in  ADDR_W  read word offset, stable while rd_req
- rd_done  out  1  one-cycle pulse: read finished (data or error)
- rd_data  out  DATA_W  captured data_sdram, valid with rd_done
- rd_err  out  1  with rd_done: read timed out, rd_data=0
- wr_req  in  1  write request, level, held until wr_ack
- wr_offset  in  ADDR_W  write word offset
- wr_data  in  DATA_W  write data
- wr_ack  out  1  one-cycle pulse, coincident with sdram_write_en
- sdram_read_en  out  1  read strobe
- sdram_write_en  out  1  write strobe
- address_sdram  out  ADDR_W  SDRAM address
- writeData_sdram  out  DATA_W  SDRAM write data
- data_sdram  in  DATA_W  SDRAM read data
- sdram_datareadvalid  in  1  read data valid
- busy  out  1  high in any state other than IDLE
- timeout_seen  out  1  sticky: any read has timed out since reset

Behaviour:
- Clock and reset: one clock, clk. Reset n_rst is asynchronous and active-low.
- Reset values:
  - State = IDLE.
  - All strobes, rd_done, rd_err, wr_ack, busy and timeout_seen = 0.
  - address_sdram, writeData_sdram and rd_data = 0.
  - last_grant = WRITE, so the first contested grant goes to READ.
- All outputs are registered.
- States: IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE.
- IDLE:
  - Samples rd_req and wr_req.
  - Only rd_req: go to RD_ISSUE. Only wr_req: go to WR_ISSUE.
  - Both: grant the side that is not last_grant, then update last_grant.
  - Neither: stay in IDLE; address and data outputs hold their last values.
- Entering RD_ISSUE:
  - address_sdram = start_addr_sdram + rd_offset, truncated to ADDR_W (wraps mod 2^26).
  - sdram_read_en = 1 for exactly that one cycle.
  - Next state is RD_WAIT unconditionally.
- RD_WAIT:
  - sdram_read_en = 0 and address is held.
  - The timeout counter starts at 0 and increments each cycle.
  - On sdram_datareadvalid: capture data_sdram into rd_data, pulse rd_done (rd_err=0) next cycle, return to IDLE.
  - If the counter reaches RD_TIMEOUT without valid: rd_done=1, rd_err=1, rd_data=0, set timeout_seen, return to IDLE.
- Valid wins when valid and timeout occur in the same cycle.
- sdram_datareadvalid is ignored in IDLE, RD_ISSUE and WR_ISSUE. Minimum read latency is therefore read_en, then 1 cycle, then valid.
- Entering WR_ISSUE:
  - address_sdram = finish_addr_sdram + wr_offset, with the same wrap rule.
  - writeData_sdram = wr_data.
  - sdram_write_en = 1 and wr_ack = 1 for one cycle.
  - Return to IDLE.
- Request rule: requesters must drop req on the edge after seeing done/ack. IDLE then sees it low and no duplicate access is issued.
- Bus timing: back-to-back accesses are separated by at least one IDLE cycle. sdram_read_en and sdram_write_en are never high together.
- Latency:
  - Write: req, then 1 cycle, then write_en.
  - Read: req, then read_en after 1 cycle, then rd_done one cycle after valid.
- Base addresses are sampled at issue only. Changing a base mid-transaction has no effect on the current access.
- Reset mid-transaction aborts immediately to reset values. No done or ack is generated.

Decomposition:
- Package sdram_arb_pkg holds:
  - ADDR_W and DATA_W localparams.
  - typedef enum logic [1:0] {IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE} arb_state_t.
  - typedef enum logic {GRANT_RD, GRANT_WR} grant_t.
- No sub-module: the FSM, address adder and timeout counter fit cleanly in one module.

Test Plan:
- Single read: start=0x100, rd_offset=5, valid 2 cycles after read_en with data 0xFF204060 -> address 0x105; read_en high 1 cycle; rd_done with rd_data=0xFF204060, rd_err=0.
- Single write: finish=0x200, wr_offset=3, wr_data=0x00A0B0C0 -> address 0x203; write_en and wr_ack high 1 cycle; writeData=0x00A0B0C0.
- Contention: rd_req and wr_req rise together and both are held through 4 accesses -> order read, write, read, write; strobes never overlap.
- Timeout: RD_TIMEOUT=4, valid never asserted -> rd_done with rd_err=1 and rd_data=0 four cycles after entering RD_WAIT; timeout_seen stays 1.
- Wrap and stray valid: start=0x3FFFFFE, rd_offset=3 -> address 0x0000001. A valid pulse in IDLE is ignored with no rd_done.
- Reset mid-read: n_rst low during RD_WAIT -> all outputs 0 immediately. After release, a new read proceeds normally.
